fm_frame_scheduler: RTL and testbench

//  Sequences one feature-map frame into the layer wrapper. Owns verticle_sync, mode_in and data_in_valid.

---
 rtl/fm_frame_scheduler_if.sv | 29 ++
 rtl/fm_frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_fm_frame_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fm_frame_scheduler_if.sv
`default_nettype none
// =============================================================================
// fm_frame_scheduler_if : pixel-source handshake and layer-wrapper signal bundle
// Rev 1.0
// =============================================================================
interface fm_frame_scheduler_if #(
  parameter int FM_DEPTH = 64,
  parameter int DATA_W   = 16
);
  logic                       src_valid;
  logic                       src_ready;
  logic [FM_DEPTH*DATA_W-1:0] src_data;
  logic                       wr_vs;
  logic                       wr_mode;
  logic                       wr_valid;
  logic [FM_DEPTH*DATA_W-1:0] wr_data;
  logic                       wr_vs_next;

  modport master (
    input  src_valid, src_data, wr_vs_next,
    output src_ready, wr_vs, wr_mode, wr_valid, wr_data
  );

  modport slave (
    output src_valid, src_data, wr_vs_next,
    input  src_ready, wr_vs, wr_mode, wr_valid, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/fm_frame_scheduler.sv
`default_nettype none
// =============================================================================
// fm_frame_scheduler : paces one feature-map frame into the layer wrapper
// Rev 1.0
// =============================================================================
module fm_frame_scheduler #(
  parameter int FM_DEPTH  = 64,
  parameter int DATA_W    = 16,
  parameter int FM_WIDTH  = 56,
  parameter int FM_HEIGHT = 56,
  parameter int PIXEL_GAP = 4,
  parameter int VS_LEAD   = 2,
  parameter int DRAIN_MAX = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode_cfg,
  fm_frame_scheduler_if.master         bus,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err,
  output logic [$clog2(FM_WIDTH)-1:0]  col_idx,
  output logic [$clog2(FM_HEIGHT)-1:0] row_idx
);
  localparam int COL_W   = $clog2(FM_WIDTH);
  localparam int ROW_W   = $clog2(FM_HEIGHT);
  localparam int LEAD_W  = (VS_LEAD > 1)   ? $clog2(VS_LEAD)   : 1;
  localparam int GAP_W   = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam int VEC_W   = FM_DEPTH * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LEAD_W-1:0]  lead_cnt_q, lead_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               wr_vs_q, wr_vs_d;
  logic               wr_mode_q, wr_mode_d;
  logic               wr_valid_q, wr_valid_d;
  logic [VEC_W-1:0]   wr_data_q, wr_data_d;
  logic               timeout_q, timeout_d;
  logic               src_ready;

  always_comb begin
    state_d     = state_q;
    lead_cnt_d  = lead_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    drain_cnt_d = drain_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    wr_vs_d     = wr_vs_q;
    wr_mode_d   = wr_mode_q;
    wr_valid_d  = 1'b0;
    wr_data_d   = wr_data_q;
    timeout_d   = timeout_q;
    src_ready   = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_mode_d  = mode_cfg;
          timeout_d  = 1'b0;
          wr_vs_d    = 1'b0;
          lead_cnt_d = LEAD_W'(VS_LEAD - 1);
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (lead_cnt_q == '0) begin
          col_d     = '0;
          row_d     = '0;
          gap_cnt_d = '0;
          state_d   = S_FEED;
        end else begin
          lead_cnt_d = lead_cnt_q - LEAD_W'(1);
        end
      end
      S_FEED: begin
        src_ready = (gap_cnt_q == '0);
        if (bus.src_valid && src_ready) begin
          wr_data_d  = bus.src_data;
          wr_valid_d = 1'b1;
          gap_cnt_d  = GAP_W'(PIXEL_GAP - 1);
          if (col_q == COL_W'(FM_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(FM_HEIGHT - 1)) begin
              // Final pixel: park the position at the origin rather than overflow row.
              row_d       = '0;
              drain_cnt_d = '0;
              state_d     = S_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DRAIN: begin
        if (bus.wr_vs_next) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_MAX - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        wr_vs_d     = 1'b1;
        lead_cnt_d  = '0;
        gap_cnt_d   = '0;
        drain_cnt_d = '0;
        col_d       = '0;
        row_d       = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lead_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wr_vs_q     <= 1'b1;
      wr_mode_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lead_cnt_q  <= lead_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_vs_q     <= wr_vs_d;
      wr_mode_q   <= wr_mode_d;
      wr_valid_q  <= wr_valid_d;
      wr_data_q   <= wr_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.wr_vs     = wr_vs_q;
  assign bus.wr_mode   = wr_mode_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_data   = wr_data_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_q;
  assign col_idx       = col_q;
  assign row_idx       = row_q;
endmodule
`default_nettype wire

// File: tb/tb_fm_frame_scheduler.sv
`default_nettype none
// =============================================================================
// tb_fm_frame_scheduler : directed self-checking bench for fm_frame_scheduler
// Rev 1.0
// =============================================================================
module tb_fm_frame_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode_cfg;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  logic [1:0] col_idx;
  logic       row_idx;
  int         total = 0;
  int         bad   = 0;

  fm_frame_scheduler_if #(.FM_DEPTH(2), .DATA_W(8)) bus ();

  fm_frame_scheduler #(
    .FM_DEPTH(2), .DATA_W(8), .FM_WIDTH(4), .FM_HEIGHT(2),
    .PIXEL_GAP(3), .VS_LEAD(2), .DRAIN_MAX(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_cfg(mode_cfg), .bus(bus),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .col_idx(col_idx), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one pixel in a ready cycle and walks through the 3-cycle spacing.
  task automatic push_pixel(input int p, input logic [15:0] val, input bit last);
    check("ready_before_px", 32'(bus.src_ready), 32'd1);
    check("col_before_px", 32'(col_idx), 32'(p % 4));
    check("row_before_px", 32'(row_idx), 32'(p / 4));
    bus.src_data = val;
    tick();
    check("wr_valid_px", 32'(bus.wr_valid), 32'd1);
    check("wr_data_px", 32'(bus.wr_data), 32'(val));
    check("ready_after_px", 32'(bus.src_ready), 32'd0);
    if (!last) begin
      tick();
      check("wr_valid_gap1", 32'(bus.wr_valid), 32'd0);
      tick();
      check("wr_valid_gap2", 32'(bus.wr_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_cfg = 1'b0;
    bus.src_valid = 1'b0; bus.src_data = '0; bus.wr_vs_next = 1'b0;
    tick(); tick();
    check("rst_wr_vs", 32'(bus.wr_vs), 32'd1);
    check("rst_wr_mode", 32'(bus.wr_mode), 32'd0);
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_ready", 32'(bus.src_ready), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_col", 32'(col_idx), 32'd0);
    check("rst_row", 32'(row_idx), 32'd0);

    // Frame 1: continuous source, wrapper acknowledges 4 cycles after the last pixel
    rst = 1'b0; start = 1'b1; mode_cfg = 1'b1; bus.src_valid = 1'b1;
    tick();
    start = 1'b0; mode_cfg = 1'b0;
    check("f1_vs_fall", 32'(bus.wr_vs), 32'd0);
    check("f1_mode", 32'(bus.wr_mode), 32'd1);
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_sync_ready0", 32'(bus.src_ready), 32'd0);
    tick();
    check("f1_sync_ready1", 32'(bus.src_ready), 32'd0);
    tick();
    for (int p = 0; p < 8; p++) push_pixel(p, 16'hA000 + 16'(p), p == 7);
    bus.src_valid = 1'b0;
    check("f1_drain_vs", 32'(bus.wr_vs), 32'd0);
    tick(); tick(); tick();
    check("f1_drain_hold", 32'(frame_done), 32'd0);
    bus.wr_vs_next = 1'b1;
    tick();
    bus.wr_vs_next = 1'b0;
    check("f1_done_pulse", 32'(frame_done), 32'd1);
    check("f1_done_busy", 32'(busy), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f1_done_low", 32'(frame_done), 32'd0);
    check("f1_vs_rise", 32'(bus.wr_vs), 32'd1);
    check("f1_idle_busy", 32'(busy), 32'd0);
    check("f1_timeout", 32'(timeout_err), 32'd0);
    check("f1_data_held", 32'(bus.wr_data), 32'hA007);
    tick();
    check("f1_start_in_done_ignored", 32'(busy), 32'd0);

    // Frame 2: mid-row stall, stray vs_next during FEED, then drain timeout
    start = 1'b1; mode_cfg = 1'b0; bus.src_valid = 1'b1;
    tick();
    start = 1'b0;
    check("f2_vs_fall", 32'(bus.wr_vs), 32'd0);
    check("f2_mode", 32'(bus.wr_mode), 32'd0);
    tick(); tick();
    push_pixel(0, 16'hB000, 1'b0);
    push_pixel(1, 16'hB001, 1'b0);
    bus.src_valid = 1'b0;
    bus.wr_vs_next = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      bus.wr_vs_next = 1'b0;
      check("f2_stall_valid", 32'(bus.wr_valid), 32'd0);
      check("f2_stall_col", 32'(col_idx), 32'd2);
      check("f2_stall_busy", 32'(busy), 32'd1);
      check("f2_stall_done", 32'(frame_done), 32'd0);
    end
    check("f2_stall_data", 32'(bus.wr_data), 32'hB001);
    bus.src_valid = 1'b1;
    for (int p = 2; p < 8; p++) push_pixel(p, 16'hB000 + 16'(p), p == 7);
    bus.src_valid = 1'b0;
    for (int d = 0; d < 15; d++) tick();
    check("f2_drain_last", 32'(frame_done), 32'd0);
    check("f2_drain_no_to", 32'(timeout_err), 32'd0);
    tick();
    check("f2_to_done", 32'(frame_done), 32'd1);
    check("f2_to_err", 32'(timeout_err), 32'd1);
    tick();
    check("f2_to_sticky", 32'(timeout_err), 32'd1);
    check("f2_to_vs", 32'(bus.wr_vs), 32'd1);
    check("f2_to_busy", 32'(busy), 32'd0);

    // Frame 3: start clears the error; reset mid-FEED aborts without frame_done
    start = 1'b1; bus.src_valid = 1'b1;
    tick();
    start = 1'b0;
    check("f3_to_clear", 32'(timeout_err), 32'd0);
    tick(); tick();
    for (int p = 0; p < 3; p++) push_pixel(p, 16'hC000 + 16'(p), 1'b0);
    bus.src_valid = 1'b0;
    start = 1'b1;
    tick();
    check("f3_start_ignored_busy", 32'(busy), 32'd1);
    check("f3_start_ignored_col", 32'(col_idx), 32'd3);
    check("f3_start_ignored_vs", 32'(bus.wr_vs), 32'd0);
    rst = 1'b1;
    tick();
    check("f3_rst_vs", 32'(bus.wr_vs), 32'd1);
    check("f3_rst_busy", 32'(busy), 32'd0);
    check("f3_rst_done", 32'(frame_done), 32'd0);
    check("f3_rst_data", 32'(bus.wr_data), 32'd0);
    check("f3_rst_col", 32'(col_idx), 32'd0);
    check("f3_rst_mode", 32'(bus.wr_mode), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("f3_after_rst_done", 32'(frame_done), 32'd0);
    check("f3_after_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
